pipeline_control_unit: RTL and testbench

PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

---
 rtl/pipeline_control_unit.sv | 118 +++++++++++
 tb/tb_pipeline_control_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit
//   Sequences an N_STAGES-deep datapath: a warm-up phase enables the stage
//   registers one at a time while the datapath muxes are forced to their
//   reset/initial operands. After warm-up, symbols are issued no more often
//   than once every ISSUE_GAP+1 cycles, and a valid bit tracks each symbol
//   down the pipe.
//
// Ports
//   clk         in   single clock, rising edge
//   reset_ctrl  in   synchronous active-high reset
//   in_valid    in   upstream offers a symbol (held while in_ready is low)
//   flush       in   drop every in-flight symbol (ignored during warm-up)
//   in_ready    out  a symbol offered this cycle is taken (unless flushing)
//   stage_en    out  bit i enables the register after stage i
//   mux_reset   out  select reset/initial operands into the stage muxes
//   out_valid   out  final stage holds a valid result
//   busy        out  at least one symbol in flight
//
// Every output is decoded from registered state only.
module pipeline_control_unit #(
    parameter int N_STAGES  = 3,
    parameter int ISSUE_GAP = 1
) (
    input  logic                clk,
    input  logic                reset_ctrl,
    input  logic                in_valid,
    input  logic                flush,
    output logic                in_ready,
    output logic [N_STAGES-1:0] stage_en,
    output logic                mux_reset,
    output logic                out_valid,
    output logic                busy
);

    if (N_STAGES < 2 || N_STAGES > 8) begin : g_bad_n_stages
        $error("pipeline_control_unit: N_STAGES must be in 2..8");
    end
    if (ISSUE_GAP < 0 || ISSUE_GAP > 7) begin : g_bad_issue_gap
        $error("pipeline_control_unit: ISSUE_GAP must be in 0..7");
    end

    // warm_cnt spans 0..N_STAGES-2; gap_cnt spans 0..ISSUE_GAP.
    localparam int WARM_W = (N_STAGES > 2) ? $clog2(N_STAGES - 1) : 1;
    localparam int GAP_W  = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;

    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(N_STAGES - 2);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(ISSUE_GAP);

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WARM_W-1:0]   warm_cnt_q, warm_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [N_STAGES-1:0] vld_q, vld_d;
    logic                accept;

    always_ff @(posedge clk) begin
        if (reset_ctrl) begin
            state_q    <= WARMUP;
            warm_cnt_q <= '0;
            gap_cnt_q  <= '0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            vld_q      <= vld_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        // in_ready is only ever high in RUN, so no accept can occur in warm-up.
        accept = in_valid && in_ready && !flush;
        vld_d  = {vld_q[N_STAGES-2:0], accept};

        case (state_q)
            WARMUP: begin
                if (warm_cnt_q == WARM_LAST) begin
                    state_d = RUN;
                end else begin
                    warm_cnt_d = warm_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (flush) begin
                    vld_d     = '0;
                    gap_cnt_d = '0;
                end else if (accept) begin
                    gap_cnt_d = GAP_LOAD;
                end else if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = WARMUP;
            end
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        for (int j = 0; j < N_STAGES; j++) begin
            stage_en[j] = (state_q == RUN) || (j <= int'(warm_cnt_q));
        end
        mux_reset = (state_q == WARMUP);
        in_ready  = (state_q == RUN) && (gap_cnt_q == '0);
        out_valid = vld_q[N_STAGES-1];
        busy      = |vld_q;
    end

endmodule

// File: tb/tb_pipeline_control_unit.sv
module tb_pipeline_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_ctrl = 1'b1;
    logic in_valid   = 1'b0;
    logic flush      = 1'b0;

    // Three configurations driven by the same stimulus; only one is checked per test.
    logic [2:0] se_a; logic ir_a, mr_a, ov_a, bz_a;   // N=3, GAP=1
    logic [2:0] se_b; logic ir_b, mr_b, ov_b, bz_b;   // N=3, GAP=0
    logic [4:0] se_c; logic ir_c, mr_c, ov_c, bz_c;   // N=5, GAP=2

    pipeline_control_unit #(.N_STAGES(3), .ISSUE_GAP(1)) u_a (
        .clk(clk), .reset_ctrl(reset_ctrl), .in_valid(in_valid), .flush(flush),
        .in_ready(ir_a), .stage_en(se_a), .mux_reset(mr_a), .out_valid(ov_a), .busy(bz_a));
    pipeline_control_unit #(.N_STAGES(3), .ISSUE_GAP(0)) u_b (
        .clk(clk), .reset_ctrl(reset_ctrl), .in_valid(in_valid), .flush(flush),
        .in_ready(ir_b), .stage_en(se_b), .mux_reset(mr_b), .out_valid(ov_b), .busy(bz_b));
    pipeline_control_unit #(.N_STAGES(5), .ISSUE_GAP(2)) u_c (
        .clk(clk), .reset_ctrl(reset_ctrl), .in_valid(in_valid), .flush(flush),
        .in_ready(ir_c), .stage_en(se_c), .mux_reset(mr_c), .out_valid(ov_c), .busy(bz_c));

    typedef struct {
        logic       rst, iv, fl;
        logic [7:0] se;
        logic       mr, ir, ov, bz;
    } step_t;

    step_t vecs[$];
    int    checks = 0;
    int    errors = 0;
    int    sel    = 0;

    logic [7:0] o_se;
    logic       o_mr, o_ir, o_ov, o_bz;

    always_comb begin
        o_se = '0; o_mr = 1'b0; o_ir = 1'b0; o_ov = 1'b0; o_bz = 1'b0;
        case (sel)
            0: begin o_se = {5'b0, se_a}; o_mr = mr_a; o_ir = ir_a; o_ov = ov_a; o_bz = bz_a; end
            1: begin o_se = {5'b0, se_b}; o_mr = mr_b; o_ir = ir_b; o_ov = ov_b; o_bz = bz_b; end
            default: begin o_se = {3'b0, se_c}; o_mr = mr_c; o_ir = ir_c; o_ov = ov_c; o_bz = bz_c; end
        endcase
    end

    function automatic void v(input logic r, input logic iv, input logic fl, input logic [7:0] se,
                               input logic mr, input logic ir, input logic ov, input logic bz);
        step_t s;
        s.rst = r; s.iv = iv; s.fl = fl; s.se = se;
        s.mr = mr; s.ir = ir; s.ov = ov; s.bz = bz;
        vecs.push_back(s);
    endfunction

    function automatic void chk(input string tname, input string nm, input int k,
                                 input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s cycle %0d got %0h expected %0h", tname, nm, k, act, exp);
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_ctrl = 1'b1; in_valid = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1 reset_ctrl = 1'b0;
    endtask

    // Applies vecs cycle by cycle starting in cycle 0 after reset. Alongside
    // the per-cycle table, a scoreboard queues the cycle in which each
    // accepted symbol must emerge (accept cycle + latency).
    task automatic run_vecs(input string tname, input int s, input int lat);
        int exp_q[$];
        int t;
        sel = s;
        do_reset();
        for (int k = 0; k < vecs.size(); k++) begin
            chk(tname, "stage_en",  k, o_se,        vecs[k].se);
            chk(tname, "mux_reset", k, {7'b0, o_mr}, {7'b0, vecs[k].mr});
            chk(tname, "in_ready",  k, {7'b0, o_ir}, {7'b0, vecs[k].ir});
            chk(tname, "out_valid", k, {7'b0, o_ov}, {7'b0, vecs[k].ov});
            chk(tname, "busy",      k, {7'b0, o_bz}, {7'b0, vecs[k].bz});

            while (exp_q.size() > 0 && exp_q[0] < k) begin
                t = exp_q.pop_front();
                checks++; errors++;
                $display("FAIL %s sb_missed cycle %0d got no out_valid expected one at cycle %0d", tname, k, t);
            end
            if (o_ov) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s sb_spurious cycle %0d got out_valid expected none", tname, k);
                end else begin
                    t = exp_q.pop_front();
                    if (t != k) begin
                        errors++;
                        $display("FAIL %s sb_latency got out_valid at cycle %0d expected cycle %0d", tname, k, t);
                    end
                end
            end

            reset_ctrl = vecs[k].rst;
            in_valid   = vecs[k].iv;
            flush      = vecs[k].fl;
            if (vecs[k].rst || vecs[k].fl) exp_q.delete();
            else if (vecs[k].iv && vecs[k].ir) exp_q.push_back(k + lat);

            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s sb_leftover got %0d pending expected 0", tname, exp_q.size());
        end
        reset_ctrl = 1'b0; in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        // N=3 GAP=1: warm-up, steady issue with in_valid held, drain.
        vecs.delete();
        v(0,1,0,8'h01,1,0,0,0); v(0,1,0,8'h03,1,0,0,0); v(0,1,0,8'h07,0,1,0,0);
        v(0,1,0,8'h07,0,0,0,1); v(0,1,0,8'h07,0,1,0,1); v(0,1,0,8'h07,0,0,1,1);
        v(0,1,0,8'h07,0,1,0,1); v(0,1,0,8'h07,0,0,1,1); v(0,1,0,8'h07,0,1,0,1);
        v(0,0,0,8'h07,0,0,1,1); v(0,0,0,8'h07,0,1,0,1); v(0,0,0,8'h07,0,1,1,1);
        v(0,0,0,8'h07,0,1,0,0);
        run_vecs("n3g1_issue", 0, 3);

        // N=3 GAP=1: reset in cycle 6 discards in-flight symbols and restarts warm-up.
        vecs.delete();
        v(0,1,0,8'h01,1,0,0,0); v(0,1,0,8'h03,1,0,0,0); v(0,1,0,8'h07,0,1,0,0);
        v(0,1,0,8'h07,0,0,0,1); v(0,1,0,8'h07,0,1,0,1); v(0,1,0,8'h07,0,0,1,1);
        v(1,1,0,8'h07,0,1,0,1); v(0,1,0,8'h01,1,0,0,0); v(0,1,0,8'h03,1,0,0,0);
        v(0,1,0,8'h07,0,1,0,0); v(0,0,0,8'h07,0,0,0,1); v(0,0,0,8'h07,0,1,0,1);
        v(0,0,0,8'h07,0,1,1,1); v(0,0,0,8'h07,0,1,0,0);
        run_vecs("n3g1_reset", 0, 3);

        // N=3 GAP=0: flush ignored in warm-up, back-to-back issue, flush beats in_valid.
        vecs.delete();
        v(0,0,1,8'h01,1,0,0,0); v(0,1,1,8'h03,1,0,0,0); v(0,1,0,8'h07,0,1,0,0);
        v(0,1,0,8'h07,0,1,0,1); v(0,1,0,8'h07,0,1,0,1); v(0,1,0,8'h07,0,1,1,1);
        v(0,0,0,8'h07,0,1,1,1); v(0,0,0,8'h07,0,1,1,1); v(0,0,0,8'h07,0,1,1,1);
        v(0,0,0,8'h07,0,1,0,0); v(0,1,1,8'h07,0,1,0,0); v(0,1,0,8'h07,0,1,0,0);
        v(0,0,0,8'h07,0,1,0,1); v(0,0,0,8'h07,0,1,0,1); v(0,0,0,8'h07,0,1,1,1);
        v(0,0,0,8'h07,0,1,0,0);
        run_vecs("n3g0_stream", 1, 3);

        // N=3 GAP=1: accepts in 2 and 4, flush in 5 kills the second symbol.
        vecs.delete();
        v(0,0,0,8'h01,1,0,0,0); v(0,0,0,8'h03,1,0,0,0); v(0,1,0,8'h07,0,1,0,0);
        v(0,1,0,8'h07,0,0,0,1); v(0,1,0,8'h07,0,1,0,1); v(0,0,1,8'h07,0,0,1,1);
        v(0,0,0,8'h07,0,1,0,0); v(0,0,0,8'h07,0,1,0,0); v(0,0,0,8'h07,0,1,0,0);
        run_vecs("n3g1_flush", 0, 3);

        // N=5 GAP=2: four warm-up cycles, issue every 3 cycles, flush clears gap.
        vecs.delete();
        v(0,1,0,8'h01,1,0,0,0); v(0,1,0,8'h03,1,0,0,0); v(0,1,0,8'h07,1,0,0,0);
        v(0,1,0,8'h0F,1,0,0,0); v(0,1,0,8'h1F,0,1,0,0); v(0,1,0,8'h1F,0,0,0,1);
        v(0,1,0,8'h1F,0,0,0,1); v(0,1,0,8'h1F,0,1,0,1); v(0,1,0,8'h1F,0,0,0,1);
        v(0,1,0,8'h1F,0,0,1,1); v(0,1,0,8'h1F,0,1,0,1); v(0,1,0,8'h1F,0,0,0,1);
        v(0,1,0,8'h1F,0,0,1,1); v(0,1,0,8'h1F,0,1,0,1); v(0,0,0,8'h1F,0,0,0,1);
        v(0,0,0,8'h1F,0,0,1,1); v(0,0,0,8'h1F,0,1,0,1); v(0,0,0,8'h1F,0,1,0,1);
        v(0,0,0,8'h1F,0,1,1,1); v(0,1,0,8'h1F,0,1,0,0); v(0,1,1,8'h1F,0,0,0,1);
        v(0,0,0,8'h1F,0,1,0,0); v(0,0,0,8'h1F,0,1,0,0);
        run_vecs("n5g2_issue", 2, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
